pwm32_capture: RTL
==================

// Module: pwm32_capture
// PURPOSE
//  Counterpart of the PWM32 generator: measures an incoming PWM waveform and reports
//  its period and high time in prescaled ticks. Sits behind the same register-style
//  bus wrapper as the generator. Results are held under a valid/ack handshake.
// PARAMETERS
//  CNT_W        32  width of the period/high counters and result registers
//  SYNC_STAGES  2   flops in the pwm_in synchroniser (>=2)
// PORTS
//  clk        in   1      single clock; all logic is on its rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  pwm_in     in   1      asynchronous PWM input
//  en         in   1      capture enable
//  inv        in   1      invert pwm_in after synchronisation (1: active-low PWM)
//  clkdiv     in   4      prescaler: one tick every clkdiv+1 clk cycles
//  timeout    in   CNT_W  ticks without an edge before declaring stuck; 0 disables
//  ack        in   1      one-cycle pulse: consume the current result
//  period     out  CNT_W  rising-to-rising edge distance, in ticks
//  high_time  out  CNT_W  rising-to-falling edge distance, in ticks
//  valid      out  1      result available; held until ack
//  overrun    out  1      sticky: a result was overwritten while valid=1 and not acked
//  sat        out  1      last result saturated (a counter hit all-ones)
//  stuck      out  1      timeout expired with no edge
//  stuck_lvl  out  1      level of the (inverted) input when stuck was set
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; counters and prescaler 0.
//  - Edge detect: compare the last sync stage with one extra flop, after inv. An edge is
//    flagged SYNC_STAGES+1 cycles after pwm_in changes.
//  - Prescaler: counts clk 0..clkdiv and ticks on wrap. It restarts at 0 on every
//    rising edge, so results are exact when the high/low times are multiples of clkdiv+1.
//  - Counters advance on ticks and saturate at all-ones. The edge cycle counts as
//    tick 1: captured value = count+1. With clkdiv=0 the results are exact clk cycles.
//  - FSM:
//      IDLE: entered when en=0.
//      ARM:  IDLE->ARM when en=1. Waits for the first rising edge, then clears
//            counters and goes to HIGH.
//      HIGH: on a falling edge, latch the high count -> LOW.
//      LOW:  on a rising edge, publish results, clear counters -> HIGH (back-to-back).
//  - Publish cycle: period and high_time update, valid=1, sat=OR of the saturation
//    flags. stuck is cleared. Outputs appear 1 cycle after the edge flag.
//  - Handshake:
//      ack clears valid and overrun in the next cycle.
//      ack while valid=0 is ignored.
//      Publish while valid=1 without ack: results are overwritten and overrun is set.
//      Publish and ack in the same cycle: valid stays 1 with the new data; overrun is
//      not set.
//  - Timeout: if timeout!=0 and the running counter reaches timeout in ARM, HIGH or LOW
//    with no edge:
//      stuck=1 and stuck_lvl=current level; go to ARM; valid is not touched.
//      The next publish clears stuck.
//  - en=0 at any time: go to IDLE next cycle. Clear counters, prescaler and stuck.
//    period, high_time, valid and overrun are retained. Re-enable starts again from ARM.
//  - Edge in the same cycle as timeout expiry: the edge wins; stuck is not set.
//  - rst_n low mid-measurement: everything is immediately at its reset values; no
//    partial result is published.
//  - Width rules: all counters are CNT_W bits, unsigned. clkdiv zero-extends into the
//    prescaler compare.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, ARM, HIGH, LOW) and the SYNC_STAGES default.
//  - Sub-module pwm32_capture_sync: an n-stage synchroniser plus edge flop; outputs the
//    level, rise and fall. It is reusable by other input-capture blocks.
//  - The FSM, prescaler, counters and result/handshake regs stay in this module.
// TESTING
//  1. clkdiv=0, 30 high / 70 low clk cycles, repeated -> after the 2nd rising edge:
//     period=100, high_time=30, valid=1.
//  2. clkdiv=3, 40 high / 60 low -> period=25, high_time=10. Saturating case: CNT_W=8,
//     period 400 cycles -> period=255, sat=1.
//  3. No ack across two periods -> overrun=1 with the second result. Then ack -> valid=0
//     and overrun=0. Also ack in the publish cycle -> valid=1, overrun=0.
//  4. timeout=50, clkdiv=0, input held high after arming -> stuck=1, stuck_lvl=1 about
//     50 cycles after the last edge. Resume the PWM -> the first publish clears stuck.
//  5. inv=1 with an inverted 30/70 waveform -> the same results as test 1. Toggle en off
//     mid-LOW -> valid retained and no publish; re-enable -> a new result after 2 edges.
//  6. Assert rst_n low mid-HIGH -> all outputs 0 immediately. After release plus en=1 ->
//     the first valid only after a full period.

Source files
------------

// File: rtl/pwm32_capture_pkg.sv
// Shared types for the PWM capture block.
// FSM encoding and synchroniser depth default.
package pwm32_capture_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } state_t;

endpackage

// File: rtl/pwm32_capture_sync.sv
// Input synchroniser with an edge flop.
// Reports the settled level plus registered rise/fall flags.
module pwm32_capture_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic inv,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sq;
  logic [STAGES:0]   fill;
  logic              cur;
  logic              lvl_q;
  logic              rise_q;
  logic              fall_q;

  assign cur = sq[STAGES-1] ^ inv;

  // No edges until the chain holds real samples, so a
  // level that is already high at reset is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq     <= '0;
      fill   <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sq     <= {sq[STAGES-2:0], din};
      fill   <= {fill[STAGES-1:0], 1'b1};
      lvl_q  <= cur;
      rise_q <= fill[STAGES] & cur & ~lvl_q;
      fall_q <= fill[STAGES] & ~cur & lvl_q;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm32_capture.sv
// PWM input capture: period and high time in prescaled ticks,
// held under a valid/ack handshake with overrun and stuck detection.
module pwm32_capture
  import pwm32_capture_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             en,
  input  logic             inv,
  input  logic [3:0]       clkdiv,
  input  logic [CNT_W-1:0] timeout,
  input  logic             ack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             overrun,
  output logic             sat,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic level;
  logic rise;
  logic fall;

  pwm32_capture_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .inv   (inv),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       pre;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] cap;
  logic             hi_sat;
  logic             cap_sat;
  logic             tick;
  logic             edge_any;
  logic             expire;
  logic             publish;
  logic             latch_hi;
  logic             restart;
  logic             to_hit;

  assign tick     = (pre == clkdiv);
  assign edge_any = rise | fall;
  // The edge cycle itself is tick 1 of the captured interval.
  assign cap      = (cnt == MAX) ? MAX : cnt + ONE;
  assign cap_sat  = (cap == MAX);
  assign expire   = (timeout != '0) && (gap >= timeout)
                    && !edge_any;

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    latch_hi  = 1'b0;
    restart   = 1'b0;
    to_hit    = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_ARM;
        ST_ARM: begin
          if (rise) begin
            restart   = 1'b1;
            state_nxt = ST_HIGH;
          end else if (expire) begin
            to_hit    = 1'b1;
            state_nxt = ST_ARM;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            latch_hi  = 1'b1;
            state_nxt = ST_LOW;
          end else if (expire) begin
            to_hit    = 1'b1;
            state_nxt = ST_ARM;
          end
        end
        ST_LOW: begin
          if (rise) begin
            publish   = 1'b1;
            restart   = 1'b1;
            state_nxt = ST_HIGH;
          end else if (expire) begin
            to_hit    = 1'b1;
            state_nxt = ST_ARM;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // gap measures ticks since the last edge of either polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      cnt       <= '0;
      gap       <= '0;
      hi_q      <= '0;
      hi_sat    <= 1'b0;
      stuck     <= 1'b0;
      stuck_lvl <= 1'b0;
    end else if (!en || state == ST_IDLE) begin
      pre <= '0;
      cnt <= '0;
      gap <= '0;
      if (!en) stuck <= 1'b0;
    end else begin
      pre <= (rise || tick) ? 4'd0 : pre + 4'd1;
      if (restart || to_hit)
        cnt <= '0;
      else if (tick && cnt != MAX && state != ST_ARM)
        cnt <= cnt + ONE;
      if (edge_any || to_hit)
        gap <= '0;
      else if (tick && gap != MAX)
        gap <= gap + ONE;
      if (latch_hi) begin
        hi_q   <= cap;
        hi_sat <= cap_sat;
      end
      if (to_hit) begin
        stuck     <= 1'b1;
        stuck_lvl <= level;
      end else if (publish) begin
        stuck <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      sat       <= 1'b0;
    end else if (publish) begin
      period    <= cap;
      high_time <= hi_q;
      sat       <= hi_sat | cap_sat;
      valid     <= 1'b1;
      overrun   <= valid & ~ack;
    end else if (ack && valid) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
